board_scanner: RTL and testbench
================================

BOARD_SCANNER -- requirements
Module: board_scanner

Interface
- REQ-001: Parameter ROWS, default 20, number of board rows scanned.
- REQ-002: Parameter COLS, default 10, number of board columns scanned.
- REQ-003: Parameter CELL_W, default 3, width of the cell code.
- REQ-004: clk  input  1  single clock; all state changes on its rising edge.
- REQ-005: reset  input  1  asynchronous, active-low reset.
- REQ-006: start  input  1  request one full-board scan.
  - Sampled only in IDLE.
- REQ-007: print_i  output  5  row address to the game engine.
- REQ-008: print_j  output  5  column address to the game engine.
- REQ-009: print_data  input  CELL_W  cell code returned by the engine.
  - Valid exactly one clk after print_i/print_j change.
- REQ-010: next_tetris  input  3  engine preview piece.
- REQ-011: pix_valid  output  1  a cell is presented on pix_*.
- REQ-012: pix_ready  input  1  downstream accepts the cell.
  - Transfer occurs when pix_valid and pix_ready are both 1 on a rising edge.
- REQ-013: pix_row  output  5  row of the presented cell.
- REQ-014: pix_col  output  5  column of the presented cell.
- REQ-015: pix_cell  output  CELL_W  code of the presented cell.
- REQ-016: preview  output  3  next_tetris latched at scan start.
- REQ-017: busy  output  1  high from scan start until the final transfer completes.
- REQ-018: frame_done  output  1  one-cycle pulse after the last cell transfers.

Function
- REQ-019: States: IDLE, ADDR, CAPT, HOLD.
- REQ-020: IDLE behaviour:
  - print_i = print_j = 0, pix_valid = 0, busy = 0.
  - start = 1 → ADDR; busy = 1 next cycle; preview <= next_tetris in the same edge.
- REQ-021: ADDR drives the current (i,j) on print_i/print_j, then → CAPT unconditionally.
- REQ-022: CAPT registers pix_cell <= print_data, pix_row <= i, pix_col <= j, pix_valid <= 1, then → HOLD.
- REQ-023: HOLD behaviour:
  - pix_valid, pix_row, pix_col and pix_cell stay constant while pix_ready = 0; no deadline.
- REQ-024: Transfer in HOLD, not last cell:
  - pix_valid <= 0.
  - Advance j; j = COLS-1 wraps j to 0 and increments i.
  - → ADDR.
- REQ-025: Transfer in HOLD, last cell (i = ROWS-1, j = COLS-1):
  - pix_valid <= 0, busy <= 0, frame_done <= 1 for one cycle.
  - i, j <= 0; → IDLE.
- REQ-026: Timing per cell:
  - With pix_ready held 1, each cell costs exactly 3 cycles (ADDR, CAPT, HOLD).
  - A full default scan is 600 cycles from the first ADDR to the final transfer.
- REQ-027: print_i/print_j hold their value through CAPT and HOLD, so the engine address is stable while data is captured.
- REQ-028: start asserted while busy is ignored.
  - A start coincident with the frame_done cycle is also ignored.
  - Only start seen in IDLE begins a scan.
- REQ-029: pix_valid never drops without a transfer, except on reset.
- REQ-030: preview is constant for the whole scan, even if next_tetris changes mid-scan.
- REQ-031: Counter widths are 5 bits; ROWS and COLS up to 32 are supported without overflow.

Reset
- REQ-032: Asserting reset (low) immediately forces:
  - IDLE.
  - i = j = 0, print_i = print_j = 0.
  - pix_valid = 0, pix_row = pix_col = 0, pix_cell = 0.
  - preview = 0, busy = 0, frame_done = 0.
- REQ-033: Reset mid-scan discards the partial frame; no frame_done is produced for it.
- REQ-034: After release, the block waits in IDLE for a new start.

Verification
- REQ-035: Reset, then a start pulse with pix_ready = 1 and a model engine returning (i+j)%8 one cycle late.
  - Expect 200 transfers in row-major order, each with pix_cell = (row+col)%8.
  - frame_done pulses once, 600 cycles after the first ADDR.
- REQ-036: pix_ready = 0 for 10 cycles at cell (0,3).
  - pix_valid stays 1; pix_row = 0, pix_col = 3 and pix_cell stay unchanged.
  - print_j stays 3; the scan resumes at (0,4) after ready.
- REQ-037: Cell (0,9) transfers.
  - Next presented cell is (1,0).
  - After (19,9): busy falls, frame_done = 1 for one cycle, print_i = print_j = 0.
- REQ-038: next_tetris = 5 at start, changed to 2 mid-scan → preview stays 5 until the next start.
- REQ-039: A second start pulse at cell (7,4) → ignored; exactly one frame_done for the frame.
- REQ-040: reset driven low at cell (12,6) while pix_valid = 1.
  - All outputs zero immediately.
  - A subsequent start rescans from (0,0).

Source files
------------

// File: rtl/board_scanner.sv
// board_scanner: walks a ROWS x COLS game board in row-major order, reading each cell
// from the game engine and presenting it on a valid/ready pixel stream.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        request a full-board scan (only honoured while idle)
//   print_i/j    row/column address to the engine (held for the whole cell)
//   print_data   cell code from the engine, valid one clk after the address changes
//   next_tetris  engine preview piece, latched into preview at scan start
//   pix_valid    a cell is presented on pix_row/pix_col/pix_cell
//   pix_ready    downstream accepts the presented cell
//   preview      preview piece captured at scan start
//   busy         high from scan start until the final transfer
//   frame_done   one-cycle pulse after the last cell transfers
//
// Each cell takes three states: ADDR puts the address out, CAPT grabs the engine
// response a cycle later, HOLD presents it until the downstream accepts.

module board_scanner #(
    parameter int unsigned ROWS   = 20,
    parameter int unsigned COLS   = 10,
    parameter int unsigned CELL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [4:0]        print_i,
    output logic [4:0]        print_j,
    input  logic [CELL_W-1:0] print_data,
    input  logic [2:0]        next_tetris,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [4:0]        pix_row,
    output logic [4:0]        pix_col,
    output logic [CELL_W-1:0] pix_cell,
    output logic [2:0]        preview,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [4:0] LastRow = 5'(ROWS - 1);
    localparam logic [4:0] LastCol = 5'(COLS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StCapt,
        StHold
    } state_t;

    state_t     state_q;
    logic [4:0] row_q;
    logic [4:0] col_q;

    // The scan position only moves on a transfer and is zero whenever idle, so it
    // doubles as the engine address: stable through CAPT and HOLD, zero in IDLE.
    assign print_i = row_q;
    assign print_j = col_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            row_q      <= 5'd0;
            col_q      <= 5'd0;
            pix_valid  <= 1'b0;
            pix_row    <= 5'd0;
            pix_col    <= 5'd0;
            pix_cell   <= '0;
            preview    <= 3'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // frame_done is only ever high in the first idle cycle; a start
                    // arriving together with it belongs to the finished frame.
                    if (start && !frame_done) begin
                        state_q <= StAddr;
                        busy    <= 1'b1;
                        preview <= next_tetris;
                    end
                end
                StAddr: begin
                    state_q <= StCapt;
                end
                StCapt: begin
                    pix_cell  <= print_data;
                    pix_row   <= row_q;
                    pix_col   <= col_q;
                    pix_valid <= 1'b1;
                    state_q   <= StHold;
                end
                StHold: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (row_q == LastRow && col_q == LastCol) begin
                            row_q      <= 5'd0;
                            col_q      <= 5'd0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            if (col_q == LastCol) begin
                                col_q <= 5'd0;
                                row_q <= row_q + 5'd1;
                            end else begin
                                col_q <= col_q + 5'd1;
                            end
                            state_q <= StAddr;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_scanner.sv
module tb_board_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] print_i;
    logic [4:0] print_j;
    logic [2:0] print_data;
    logic [2:0] next_tetris;
    logic       pix_valid;
    logic       pix_ready;
    logic [4:0] pix_row;
    logic [4:0] pix_col;
    logic [2:0] pix_cell;
    logic [2:0] preview;
    logic       busy;
    logic       frame_done;

    int n_cmp = 0;
    int n_fail = 0;
    int fd_count = 0;

    board_scanner #(
        .ROWS   (20),
        .COLS   (10),
        .CELL_W (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .print_i     (print_i),
        .print_j     (print_j),
        .print_data  (print_data),
        .next_tetris (next_tetris),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_row     (pix_row),
        .pix_col     (pix_col),
        .pix_cell    (pix_cell),
        .preview     (preview),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Engine model: registered response one clk after the address.
    always @(posedge clk) print_data <= 3'((32'(print_i) + 32'(print_j)) % 8);

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Step to the next HOLD cycle (bounded) and check the presented cell.
    task automatic wait_hold(input int r, input int c);
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (pix_valid !== 1'b1 && cnt < 8);
        check("hold_reached", 32'(pix_valid), 1);
        check("hold_row", 32'(pix_row), r);
        check("hold_col", 32'(pix_col), c);
        check("hold_cell", 32'(pix_cell), (r + c) % 8);
    endtask

    initial begin
        int k;
        int ph;
        int r;
        int c;

        reset       = 1'b0;
        start       = 1'b0;
        pix_ready   = 1'b1;
        next_tetris = 3'd5;
        repeat (3) @(negedge clk);

        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(pix_valid), 0);
        check("rst_print_i", 32'(print_i), 0);
        check("rst_print_j", 32'(print_j), 0);
        check("rst_preview", 32'(preview), 0);
        check("rst_frame_done", 32'(frame_done), 0);

        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Frame 1: ready held high, exact 3-cycle cadence over 200 cells.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 600; n++) begin
            k  = n / 3;
            ph = n % 3;
            r  = k / 10;
            c  = k % 10;
            if (ph == 0) begin
                check("addr_busy", 32'(busy), 1);
                check("addr_print_i", 32'(print_i), r);
                check("addr_print_j", 32'(print_j), c);
                check("addr_valid", 32'(pix_valid), 0);
                if (k == 100) next_tetris = 3'd2;
                if (k == 74) start = 1'b1;
            end else if (ph == 1) begin
                check("capt_valid", 32'(pix_valid), 0);
                check("capt_print_j", 32'(print_j), c);
                start = 1'b0;
            end else begin
                check("hold_valid", 32'(pix_valid), 1);
                check("hold_row", 32'(pix_row), r);
                check("hold_col", 32'(pix_col), c);
                check("hold_cell", 32'(pix_cell), (r + c) % 8);
                check("hold_preview", 32'(preview), 5);
                check("hold_print_i", 32'(print_i), r);
            end
            @(negedge clk);
        end

        // Cycle right after the final transfer.
        check("end_frame_done", 32'(frame_done), 1);
        check("end_busy", 32'(busy), 0);
        check("end_valid", 32'(pix_valid), 0);
        check("end_print_i", 32'(print_i), 0);
        check("end_print_j", 32'(print_j), 0);
        start = 1'b1;  // coincident with frame_done: must be ignored
        @(negedge clk);
        start = 1'b0;
        check("fd_one_cycle", 32'(frame_done), 0);
        check("start_at_fd_ignored", 32'(busy), 0);
        check("fd_count_frame1", 32'(fd_count), 1);
        check("preview_kept", 32'(preview), 5);
        @(negedge clk);
        check("still_idle", 32'(busy), 0);

        // Frame 2: preview relatch, stall at (0,3), reset at (12,6).
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("f2_preview", 32'(preview), 2);
        check("f2_busy", 32'(busy), 1);
        for (int n = 0; n < 4; n++) wait_hold(n / 10, n % 10);
        pix_ready = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("stall_valid", 32'(pix_valid), 1);
            check("stall_row", 32'(pix_row), 0);
            check("stall_col", 32'(pix_col), 3);
            check("stall_cell", 32'(pix_cell), 3);
            check("stall_print_j", 32'(print_j), 3);
        end
        pix_ready = 1'b1;
        @(negedge clk);
        check("resume_print_j", 32'(print_j), 4);
        check("resume_valid", 32'(pix_valid), 0);
        for (int n = 4; n <= 126; n++) wait_hold(n / 10, n % 10);

        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(pix_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_row", 32'(pix_row), 0);
        check("mid_rst_col", 32'(pix_col), 0);
        check("mid_rst_cell", 32'(pix_cell), 0);
        check("mid_rst_print_i", 32'(print_i), 0);
        check("mid_rst_print_j", 32'(print_j), 0);
        check("mid_rst_preview", 32'(preview), 0);
        check("mid_rst_frame_done", 32'(frame_done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("no_fd_after_reset", 32'(fd_count), 1);
        check("post_rst_idle", 32'(busy), 0);

        // Frame 3: rescan from (0,0).
        next_tetris = 3'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("f3_busy", 32'(busy), 1);
        check("f3_print_i", 32'(print_i), 0);
        check("f3_print_j", 32'(print_j), 0);
        check("f3_preview", 32'(preview), 6);
        wait_hold(0, 0);
        wait_hold(0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
